mod_index_gen: RTL



---
 rtl/mod_pkg.sv | 13 +
 rtl/mod_sync_if.sv | 23 ++
 rtl/mod_index_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/mod_pkg.sv
// Shared constants and state type for the modulation index generator.
package mod_pkg;

   localparam int MOD_IDX_WIDTH = 16;
   localparam int TIME_WIDTH    = 64;

   typedef enum logic [1:0] {
      WAIT_INIT = 2'd0,
      ARMED     = 2'd1,
      RUN       = 2'd2
   } mod_state_t;

endpackage

// File: rtl/mod_sync_if.sv
// Modulation clock configuration bundle driven by the config manager.
interface mod_sync_if;
   import mod_pkg::*;

   logic                     MOD_CLK_INIT;
   logic [MOD_IDX_WIDTH-1:0] MOD_CLK_CYCLE;
   logic [15:0]              MOD_CLK_DIV;
   logic [TIME_WIDTH-1:0]    MOD_CLK_SYNC_TIME_NS;

   modport slave_port (
      input MOD_CLK_INIT,
      input MOD_CLK_CYCLE,
      input MOD_CLK_DIV,
      input MOD_CLK_SYNC_TIME_NS
   );

   modport master_port (
      output MOD_CLK_INIT,
      output MOD_CLK_CYCLE,
      output MOD_CLK_DIV,
      output MOD_CLK_SYNC_TIME_NS
   );
endinterface

// File: rtl/mod_index_gen.sv
// Modulation buffer index generator: arms on an init edge, starts at a global
// sync time, then advances the index every (DIV+1) sample strobes, wrapping at CYCLE.
module mod_index_gen
   import mod_pkg::*;
#(
   parameter int MOD_IDX_WIDTH = mod_pkg::MOD_IDX_WIDTH,
   parameter int TIME_WIDTH    = mod_pkg::TIME_WIDTH
) (
   input  logic                     CLK,
   input  logic                     RST,
   mod_sync_if.slave_port           MOD_SYNC,
   input  logic [TIME_WIDTH-1:0]    SYS_TIME_NS,
   input  logic                     UPDATE,
   output logic [MOD_IDX_WIDTH-1:0] MOD_IDX,
   output logic                     MOD_IDX_UPDATE,
   output logic                     RUNNING
);

   mod_state_t               state_r, state_nxt_s;
   logic [MOD_IDX_WIDTH-1:0] idx_r, idx_nxt_s;
   logic [15:0]              div_cnt_r, div_cnt_nxt_s;
   logic [TIME_WIDTH-1:0]    sync_target_r, sync_target_nxt_s;
   logic                     upd_r, upd_nxt_s;
   logic                     run_r;
   logic                     init_prev_r;
   logic                     init_low_seen_r;
   logic                     init_evt_s;
   logic                     sync_hit_s;

   // A flag already high when reset releases must drop before a rise counts.
   assign init_evt_s = MOD_SYNC.MOD_CLK_INIT & ~init_prev_r & init_low_seen_r;
   assign sync_hit_s = (SYS_TIME_NS >= sync_target_r);

   // State, index and bookkeeping registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r         <= WAIT_INIT;
         idx_r           <= '0;
         div_cnt_r       <= 16'd0;
         sync_target_r   <= '0;
         upd_r           <= 1'b0;
         run_r           <= 1'b0;
         init_prev_r     <= 1'b0;
         init_low_seen_r <= 1'b0;
      end else begin
         state_r         <= state_nxt_s;
         idx_r           <= idx_nxt_s;
         div_cnt_r       <= div_cnt_nxt_s;
         sync_target_r   <= sync_target_nxt_s;
         upd_r           <= upd_nxt_s;
         run_r           <= (state_nxt_s == RUN);
         init_prev_r     <= MOD_SYNC.MOD_CLK_INIT;
         init_low_seen_r <= init_low_seen_r | ~MOD_SYNC.MOD_CLK_INIT;
      end
   end

   // Next-state logic; an init event overrides everything else in any state.
   always_comb begin
      state_nxt_s       = state_r;
      idx_nxt_s         = idx_r;
      div_cnt_nxt_s     = div_cnt_r;
      sync_target_nxt_s = sync_target_r;
      upd_nxt_s         = 1'b0;
      if (init_evt_s) begin
         sync_target_nxt_s = MOD_SYNC.MOD_CLK_SYNC_TIME_NS;
         state_nxt_s       = ARMED;
      end else begin
         case (state_r)
            WAIT_INIT: begin
               state_nxt_s = WAIT_INIT;
            end
            ARMED: begin
               if (sync_hit_s) begin
                  state_nxt_s   = RUN;
                  idx_nxt_s     = '0;
                  div_cnt_nxt_s = 16'd0;
                  upd_nxt_s     = 1'b1;
               end else begin
                  state_nxt_s = ARMED;
               end
            end
            RUN: begin
               if (UPDATE) begin
                  if (div_cnt_r == MOD_SYNC.MOD_CLK_DIV) begin
                     div_cnt_nxt_s = 16'd0;
                     upd_nxt_s     = 1'b1;
                     if (idx_r >= MOD_SYNC.MOD_CLK_CYCLE) begin
                        idx_nxt_s = '0;
                     end else begin
                        idx_nxt_s = idx_r + MOD_IDX_WIDTH'(1);
                     end
                  end else begin
                     div_cnt_nxt_s = div_cnt_r + 16'd1;
                  end
               end else begin
                  div_cnt_nxt_s = div_cnt_r;
               end
            end
            default: begin
               state_nxt_s = WAIT_INIT;
            end
         endcase
      end
   end

   assign MOD_IDX        = idx_r;
   assign MOD_IDX_UPDATE = upd_r;
   assign RUNNING        = run_r;

endmodule
